// File: rtl/udp_frame_buf_pkg.sv
// Shared definitions for the UDP store-and-forward payload frame buffer.
// Optional statistics counters are enabled with UDP_FRAME_BUF_STATS_EN.
package udp_frame_buf_pkg;

    // Write-side frame FSM
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } wr_state_t;

    // Each stored entry is {tlast, tdata}
    localparam int ENTRY_W = 9;

    // Width of the frame statistics counters
    localparam int CNT_W = 16;

endpackage

// File: rtl/udp_frame_buf_ram.sv
// Simple dual-port storage for the frame buffer: one write port and one
// registered read port. The array has no reset; validity is tracked outside.
module udp_frame_buf_ram
    import udp_frame_buf_pkg::*;
#(
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its value while rd_en is low
    always_ff @(posedge clock) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/udp_frame_buffer.sv
// Store-and-forward UDP payload frame buffer. A frame becomes visible to the
// transmit side only after its good tlast beat; bad (tuser) and overflowing
// frames are rewound away. The receive side never back-pressures.
// Define UDP_FRAME_BUF_STATS_EN to add good/bad/overflow frame counters.
module udp_frame_buffer
    import udp_frame_buf_pkg::*;
#(
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tuser,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    output logic             frame_avail
`ifdef UDP_FRAME_BUF_STATS_EN
    ,
    output logic [CNT_W-1:0] good_frames,
    output logic [CNT_W-1:0] bad_frames,
    output logic [CNT_W-1:0] ovf_frames
`endif
);

    localparam logic [ADDR_W:0] DEPTH_PTR = {1'b1, {ADDR_W{1'b0}}};

    logic               s_axis_tready_reg;
    wr_state_t          wr_state_reg;
    logic [ADDR_W:0]    wr_ptr_reg;
    logic [ADDR_W:0]    wr_commit_reg;
    logic [ADDR_W:0]    rd_ptr_reg;
    logic [ADDR_W:0]    ptr_diff;
    logic               full;
    logic               beat;
    logic               wr_en;
    logic               rd_en;
    logic               mem_move;
    logic               mem_valid_reg;
    logic               out_valid_reg;
    logic               out_last_reg;
    logic [7:0]         out_data_reg;
    logic [ENTRY_W-1:0] rd_data;

`ifdef UDP_FRAME_BUF_STATS_EN
    logic [CNT_W-1:0]   good_cnt_reg;
    logic [CNT_W-1:0]   bad_cnt_reg;
    logic [CNT_W-1:0]   ovf_cnt_reg;

    assign good_frames = good_cnt_reg;
    assign bad_frames  = bad_cnt_reg;
    assign ovf_frames  = ovf_cnt_reg;
`endif

    // Occupancy counts everything not yet handed to the output pipeline,
    // including the speculative part of the frame being written.
    assign ptr_diff = wr_ptr_reg - rd_ptr_reg;
    assign full     = (ptr_diff == DEPTH_PTR);
    assign beat     = s_axis_tvalid && s_axis_tready_reg;
    assign wr_en    = beat && !full && (wr_state_reg != DROP);

    // The read register advances into the output register whenever the
    // output register is empty or being consumed this cycle.
    assign mem_move = mem_valid_reg && (!out_valid_reg || m_axis_tready);
    assign rd_en    = (rd_ptr_reg != wr_commit_reg) && (!mem_valid_reg || mem_move);

    assign s_axis_tready = s_axis_tready_reg;
    assign m_axis_tdata  = out_data_reg;
    assign m_axis_tvalid = out_valid_reg;
    assign m_axis_tlast  = out_last_reg;
    assign m_axis_tuser  = 1'b0;
    assign frame_avail   = (rd_ptr_reg != wr_commit_reg) || mem_valid_reg || out_valid_reg;

    udp_frame_buf_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_reg[ADDR_W-1:0]),
        .wr_data ({s_axis_tlast, s_axis_tdata}),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_reg[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    // Write-side FSM: store, commit, or rewind each incoming frame
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s_axis_tready_reg <= 1'b0;
            wr_state_reg      <= IDLE;
            wr_ptr_reg        <= '0;
            wr_commit_reg     <= '0;
`ifdef UDP_FRAME_BUF_STATS_EN
            good_cnt_reg      <= '0;
            bad_cnt_reg       <= '0;
            ovf_cnt_reg       <= '0;
`endif
        end else begin
            s_axis_tready_reg <= 1'b1;
            if (beat) begin
                case (wr_state_reg)
                    IDLE, WRITE: begin
                        if (!full) begin
                            if (s_axis_tlast) begin
                                wr_state_reg <= IDLE;
                                if (s_axis_tuser) begin
                                    wr_ptr_reg <= wr_commit_reg;
`ifdef UDP_FRAME_BUF_STATS_EN
                                    bad_cnt_reg <= bad_cnt_reg + 1'b1;
`endif
                                end else begin
                                    wr_ptr_reg    <= wr_ptr_reg + 1'b1;
                                    wr_commit_reg <= wr_ptr_reg + 1'b1;
`ifdef UDP_FRAME_BUF_STATS_EN
                                    good_cnt_reg  <= good_cnt_reg + 1'b1;
`endif
                                end
                            end else begin
                                wr_ptr_reg   <= wr_ptr_reg + 1'b1;
                                wr_state_reg <= WRITE;
                            end
                        end else if (s_axis_tlast) begin
                            // Overflow on the last beat: discard immediately
                            wr_ptr_reg   <= wr_commit_reg;
                            wr_state_reg <= IDLE;
`ifdef UDP_FRAME_BUF_STATS_EN
                            ovf_cnt_reg  <= ovf_cnt_reg + 1'b1;
`endif
                        end else begin
                            wr_state_reg <= DROP;
                        end
                    end
                    DROP: begin
                        if (s_axis_tlast) begin
                            wr_ptr_reg   <= wr_commit_reg;
                            wr_state_reg <= IDLE;
`ifdef UDP_FRAME_BUF_STATS_EN
                            ovf_cnt_reg  <= ovf_cnt_reg + 1'b1;
`endif
                        end
                    end
                    default: wr_state_reg <= IDLE;
                endcase
            end
        end
    end

    // Read side: read pointer plus two-stage output pipeline
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_reg    <= '0;
            mem_valid_reg <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                mem_valid_reg <= 1'b1;
            end else if (mem_move) begin
                mem_valid_reg <= 1'b0;
            end
            if (mem_move) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= rd_data[7:0];
                out_last_reg  <= rd_data[8];
            end else if (m_axis_tready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_udp_frame_buffer.sv
// Self-checking bench for udp_frame_buffer. Two instances: DEPTH=2048 (index 0)
// and DEPTH=16 (index 1). Expected output is a queue of {tlast,data} per
// instance, filled from a frame-level model: a frame is emitted iff it is
// good and fits in the space not already taken by queued frames.
`timescale 1ns/1ps
module tb_udp_frame_buffer;

    localparam int DEPTH_A = 2048;
    localparam int DEPTH_B = 16;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] s_tdata   [2];
    logic       s_tvalid  [2];
    logic       s_tlast   [2];
    logic       s_tuser   [2];
    logic       s_tready  [2];
    logic [7:0] m_tdata   [2];
    logic       m_tvalid  [2];
    logic       m_tready  [2];
    logic       m_tlast   [2];
    logic       m_tuser   [2];
    logic       frame_avail [2];
`ifdef UDP_FRAME_BUF_STATS_EN
    logic [15:0] good_cnt [2];
    logic [15:0] bad_cnt  [2];
    logic [15:0] ovf_cnt  [2];
`endif

    always #5 clock = ~clock;

    udp_frame_buffer #(.DEPTH(DEPTH_A)) dut_a (
        .clock(clock), .reset_n(reset_n),
        .s_axis_tdata(s_tdata[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
        .s_axis_tlast(s_tlast[0]), .s_axis_tuser(s_tuser[0]),
        .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]),
        .m_axis_tlast(m_tlast[0]), .m_axis_tuser(m_tuser[0]),
        .frame_avail(frame_avail[0])
`ifdef UDP_FRAME_BUF_STATS_EN
        , .good_frames(good_cnt[0]), .bad_frames(bad_cnt[0]), .ovf_frames(ovf_cnt[0])
`endif
    );

    udp_frame_buffer #(.DEPTH(DEPTH_B)) dut_b (
        .clock(clock), .reset_n(reset_n),
        .s_axis_tdata(s_tdata[1]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
        .s_axis_tlast(s_tlast[1]), .s_axis_tuser(s_tuser[1]),
        .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]),
        .m_axis_tlast(m_tlast[1]), .m_axis_tuser(m_tuser[1]),
        .frame_avail(frame_avail[1])
`ifdef UDP_FRAME_BUF_STATS_EN
        , .good_frames(good_cnt[1]), .bad_frames(bad_cnt[1]), .ovf_frames(ovf_cnt[1])
`endif
    );

    int checks = 0;
    int errors = 0;
    int exp_good [2];
    int exp_bad  [2];
    int exp_ovf  [2];
    int out_count [2];
    bit rnd_rdy = 1'b0;
    logic [8:0] exp_q0 [$];
    logic [8:0] exp_q1 [$];
    logic       held [2];
    logic [8:0] held_beat [2];

    typedef struct {
        int len;
        bit tuser;
        int exp_out;
    } vec_t;
    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [8:0] qfront(input int k);
        return (k == 0) ? exp_q0[0] : exp_q1[0];
    endfunction

    task automatic qpop(input int k);
        if (k == 0) void'(exp_q0.pop_front());
        else        void'(exp_q1.pop_front());
    endtask

    task automatic qpush(input int k, input logic [8:0] v);
        if (k == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endtask

    // Output monitor: compare beats with the expected queue, check stall hold
    task automatic monitor_port(input int k);
        if (!reset_n) begin
            held[k] = 1'b0;
            return;
        end
        if (held[k])
            check($sformatf("stall_hold%0d", k), {m_tvalid[k], m_tlast[k], m_tdata[k]}, {1'b1, held_beat[k]});
        if (m_tvalid[k]) begin
            if (qsize(k) == 0) begin
                check($sformatf("unexpected_beat%0d", k), m_tvalid[k], 0);
            end else begin
                check($sformatf("beat%0d", k), {m_tuser[k], m_tlast[k], m_tdata[k]}, {1'b0, qfront(k)});
                if (m_tready[k]) begin
                    qpop(k);
                    out_count[k]++;
                end
            end
        end
        held[k]      = m_tvalid[k] && !m_tready[k];
        held_beat[k] = {m_tlast[k], m_tdata[k]};
    endtask

    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) monitor_port(k);
    end

    task automatic tick();
        @(posedge clock);
        #1;
        if (rnd_rdy) m_tready[0] = 1'($urandom_range(0, 1));
    endtask

    // Send one frame; model decides whether it should come out
    task automatic send_frame(input int k, input int len, input bit tuser, input bit ramp, input bit gaps);
        logic [8:0] fr [$];
        logic [7:0] d;
        int room;
        bit fits;
        room = ((k == 0) ? DEPTH_A : DEPTH_B) - qsize(k);
        fits = (len <= room);
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_tvalid[k] = 1'b0;
                tick();
            end
            d = ramp ? 8'(i) : 8'($urandom);
            s_tvalid[k] = 1'b1;
            s_tdata[k]  = d;
            s_tlast[k]  = (i == len - 1);
            s_tuser[k]  = (i == len - 1) ? tuser : 1'($urandom);
            fr.push_back({s_tlast[k], d});
            tick();
        end
        s_tvalid[k] = 1'b0;
        s_tlast[k]  = 1'b0;
        s_tuser[k]  = 1'b0;
        if (fits && !tuser) begin
            foreach (fr[i]) qpush(k, fr[i]);
            exp_good[k]++;
        end else if (fits) begin
            exp_bad[k]++;
        end else begin
            exp_ovf[k]++;
        end
        $display("frame dut%0d len=%0d tuser=%0d kept=%0d", k, len, tuser, fits && !tuser);
    endtask

    task automatic drain(input int k, input int budget, input string name);
        int n;
        n = 0;
        while (qsize(k) != 0 && n < budget) begin
            tick();
            n++;
        end
        check({name, "_drained"}, qsize(k), 0);
        tick();
        tick();
        check({name, "_frame_avail"}, frame_avail[k], 0);
    endtask

    task automatic check_stats(input int k);
`ifdef UDP_FRAME_BUF_STATS_EN
        check($sformatf("good_frames%0d", k), good_cnt[k], exp_good[k] & 16'hFFFF);
        check($sformatf("bad_frames%0d", k),  bad_cnt[k],  exp_bad[k] & 16'hFFFF);
        check($sformatf("ovf_frames%0d", k),  ovf_cnt[k],  exp_ovf[k] & 16'hFFFF);
`else
        check($sformatf("tuser_low%0d", k), m_tuser[k], 0);
`endif
    endtask

    initial begin
        int n;
        int start;
        tbl[0] = '{len: 20,   tuser: 1'b1, exp_out: 0};
        tbl[1] = '{len: 10,   tuser: 1'b0, exp_out: 10};
        tbl[2] = '{len: 1,    tuser: 1'b0, exp_out: 1};
        tbl[3] = '{len: 2049, tuser: 1'b0, exp_out: 0};
        tbl[4] = '{len: 2048, tuser: 1'b0, exp_out: 2048};
        tbl[5] = '{len: 5,    tuser: 1'b1, exp_out: 0};
        tbl[6] = '{len: 3,    tuser: 1'b0, exp_out: 3};

        for (int k = 0; k < 2; k++) begin
            s_tdata[k] = '0; s_tvalid[k] = 1'b0; s_tlast[k] = 1'b0; s_tuser[k] = 1'b0;
            m_tready[k] = 1'b0; held[k] = 1'b0; held_beat[k] = '0;
            exp_good[k] = 0; exp_bad[k] = 0; exp_ovf[k] = 0; out_count[k] = 0;
        end

        // Reset state
        reset_n = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            check("rst_s_tready", s_tready[k], 0);
            check("rst_m_tvalid", m_tvalid[k], 0);
            check("rst_m_tdata", {m_tlast[k], m_tdata[k]}, 0);
            check("rst_frame_avail", frame_avail[k], 0);
        end
        reset_n = 1'b1;
        #1;
        check("release_s_tready_before_edge", s_tready[0], 0);
        tick();
        check("release_s_tready_a", s_tready[0], 1);
        check("release_s_tready_b", s_tready[1], 1);
        check_stats(0);

        // 64-byte ramp frame with commit-to-output latency
        m_tready[0] = 1'b1;
        send_frame(0, 64, 1'b0, 1'b1, 1'b0);
        check("lat_edge_n", m_tvalid[0], 0);
        tick();
        check("lat_edge_n1", m_tvalid[0], 0);
        tick();
        check("lat_edge_n2", m_tvalid[0], 1);
        drain(0, 200, "ramp64");
        check_stats(0);

        // Table-driven frames (bad, good, 1-byte, oversize, exact fit)
        rnd_rdy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            start = out_count[0];
            send_frame(0, tbl[i].len, tbl[i].tuser, 1'b0, 1'b1);
            drain(0, 8 * tbl[i].len + 100, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_out_bytes", i), out_count[0] - start, tbl[i].exp_out);
        end
        check_stats(0);
        rnd_rdy = 1'b0;

        // DEPTH=16: overflow with stalled output, then exact-fit frame
        m_tready[1] = 1'b0;
        send_frame(1, 20, 1'b0, 1'b1, 1'b0);
        repeat (5) tick();
        check("b_ovf_tvalid", m_tvalid[1], 0);
        check("b_ovf_frame_avail", frame_avail[1], 0);
        check_stats(1);
        send_frame(1, 16, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        check("b_fit_frame_avail", frame_avail[1], 1);
        check("b_fit_tvalid", m_tvalid[1], 1);
        m_tready[1] = 1'b1;
        drain(1, 100, "b_fit");
        check_stats(1);

        // Back-to-back frames 1,7,300 drain with no idle cycle
        m_tready[0] = 1'b0;
        send_frame(0, 1, 1'b0, 1'b0, 1'b0);
        send_frame(0, 7, 1'b0, 1'b0, 1'b0);
        send_frame(0, 300, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        m_tready[0] = 1'b1;
        n = 0;
        while (qsize(0) != 0 && n < 1000) begin
            tick();
            n++;
        end
        check("b2b_cycles", n, 308);

        // Same lengths with pseudo-random m_tready
        rnd_rdy = 1'b1;
        send_frame(0, 1, 1'b0, 1'b0, 1'b0);
        send_frame(0, 7, 1'b0, 1'b0, 1'b0);
        send_frame(0, 300, 1'b0, 1'b0, 1'b0);
        drain(0, 3000, "rnd_b2b");

        // Random frames, random bad flag, random gaps and stalls
        for (int i = 0; i < 25; i++)
            send_frame(0, $urandom_range(1, 40), ($urandom_range(0, 3) == 0), 1'b0, 1'b1);
        drain(0, 3000, "rnd_frames");
        check_stats(0);
        rnd_rdy = 1'b0;

        // Reset mid-frame with two committed frames unread
        m_tready[0] = 1'b0;
        send_frame(0, 12, 1'b0, 1'b0, 1'b0);
        send_frame(0, 9, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            s_tvalid[0] = 1'b1;
            s_tdata[0]  = 8'($urandom);
            s_tlast[0]  = 1'b0;
            tick();
        end
        check("pre_reset_frame_avail", frame_avail[0], 1);
        reset_n = 1'b0;
        s_tvalid[0] = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        for (int k = 0; k < 2; k++) begin
            exp_good[k] = 0; exp_bad[k] = 0; exp_ovf[k] = 0;
        end
        tick();
        tick();
        check("midrst_s_tready", s_tready[0], 0);
        check("midrst_m_tvalid", m_tvalid[0], 0);
        reset_n = 1'b1;
        tick();
        m_tready[0] = 1'b1;
        repeat (10) tick();
        check("post_rst_tvalid", m_tvalid[0], 0);
        check("post_rst_frame_avail", frame_avail[0], 0);
        check_stats(0);
        send_frame(0, 5, 1'b0, 1'b0, 1'b0);
        drain(0, 50, "post_rst");
        check_stats(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
